ao486_l15_ifill_responder: RTL
==============================

Name: ao486_l15_ifill_responder

Overview:
- L1.5-side responder model for the ao486 transducer: the other end of the transducer_l15 / l15_transducer interface.
- After reset, waits a programmable delay, then issues the wake-up INT_RET that releases the ao486 core.
- Then services IMISS_RQ requests from a preloadable 128-bit line memory, returning IFILL_RET with big-endian line data.
- Used as a standalone L1.5 stand-in for transducer bring-up and verification.

Parameters:
- LINE_IDX_W, 8: line-memory index width; depth = 2**LINE_IDX_W 16-byte lines.
- RESP_LATENCY, 4: cycles from header_ack pulse to response valid; legal range 1..255.
- WAKE_DELAY, 16: cycles after reset deassertion before INT_RET is presented; legal range 1..65535.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- transducer_l15_val  in  1  request valid.
- transducer_l15_rqtype  in  5  request type.
- transducer_l15_address  in  40  request byte address.
- transducer_l15_req_ack  in  1  response consumed.
- l15_transducer_header_ack  out  1  request accepted (1-cycle pulse).
- l15_transducer_ack  out  1  equal to header_ack.
- l15_transducer_val  out  1  response valid.
- l15_transducer_returntype  out  4  IFILL_RET or INT_RET.
- l15_transducer_data_0..3  out  64 each  response payload.
- l15_transducer_noncacheable  out  1  tied 0.
- l15_transducer_atomic  out  1  tied 0.
- mem_wr_en  in  1  line-memory write strobe.
- mem_wr_idx  in  LINE_IDX_W  line-memory write index.
- mem_wr_data  in  128  line data; bits [127:120] hold byte 0.
- err_unsupported  out  1  sticky flag: a non-IMISS_RQ request was received.

Behaviour:
- Codes: IMISS_RQ, IFILL_RET and INT_RET come from the shared L1.5 define header.
- Reset, async, while rst_n=0:
  - all outputs 0; state=WAKE; wake counter=0; err_unsupported=0.
  - Line memory contents are not reset.
- States:
  - WAKE: count WAKE_DELAY cycles, then go to INT.
  - INT: val=1, returntype=INT_RET, data_0[17:16]=2'b01, all other data bits 0. Hold until req_ack=1 is sampled, then go to IDLE.
  - IDLE: on a sampled val=1, latch the address and pulse header_ack the next cycle (exactly 1 cycle).
    - rqtype==IMISS_RQ: go to WAIT.
    - any other rqtype: set err_unsupported, stay in IDLE, send no response.
  - WAIT: count RESP_LATENCY cycles after the header_ack cycle, then read line index = address[LINE_IDX_W+3:4] into the data registers and go to RESP.
  - RESP: val=1, returntype=IFILL_RET.
    - data_2 = line[127:64] (bytes 0-7); data_3 = line[63:0]; data_0 = data_1 = 0.
    - Hold val and data stable until req_ack=1 is sampled; val drops the next cycle; go to IDLE.
- Timing:
  - Minimum request-to-response-valid = 1 + RESP_LATENCY cycles from the cycle the request is sampled.
  - A new request can be accepted the cycle after val drops.
- Request valid outside IDLE (WAKE/INT/WAIT/RESP): no header_ack. The requester must hold val/rqtype/address until header_ack.
- Address:
  - Bits [3:0] are ignored (line-aligned).
  - Index bits above LINE_IDX_W+3 are discarded, so addresses wrap modulo the memory size.
- Memory:
  - A write takes effect at the clock edge.
  - A write to the index being read on the WAIT->RESP edge returns the old data.
  - Writes during RESP do not alter the held data.
- Asserting req_ack while val=0 is ignored.
- Reset mid-transaction aborts the transaction immediately and re-enters WAKE; INT_RET is resent.
- err_unsupported clears only on reset.

Optional Feature:
- Macro AO486_RESP_LFSR_DELAY_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - WAIT length = RESP_LATENCY + lfsr[2:0] sampled at header_ack, i.e. RESP_LATENCY..RESP_LATENCY+7.
- Undefined: fixed RESP_LATENCY; no LFSR logic is present.

Test Plan:
- Wake-up: release reset, hold req_ack=0 → val rises after WAKE_DELAY=16 cycles with returntype=INT_RET and data_0=64'h0000_0000_0001_0000. It stays up until req_ack=1, then drops the next cycle.
- Basic IFILL: preload idx 3 = 128'h00112233_44556677_8899AABB_CCDDEEFF; request IMISS_RQ with address 40'h30 → header_ack 1 cycle after val. Response valid 4 cycles after header_ack with data_2=64'h0011223344556677 and data_3=64'h8899AABBCCDDEEFF.
- Backpressure: hold req_ack=0 for 10 cycles during RESP → val and data stable for the whole window. A second request held during this time gets no header_ack until after val drops.
- Wrap and offset: with LINE_IDX_W=8, address 40'h1035 → index 3 is returned (offset and upper bits ignored).
- Unsupported request: rqtype≠IMISS_RQ → one header_ack pulse, err_unsupported=1, no val. The next IMISS_RQ is still serviced normally.
- Mid-operation reset: assert rst_n=0 during WAIT → all outputs 0 asynchronously. After release, INT_RET reappears 16 cycles later; with AO486_RESP_LFSR_DELAY_EN defined, WAIT length stays within 4..11 cycles.

Source files
------------

// File: rtl/ao486_l15_ifill_responder.sv
// ao486_l15_ifill_responder: L1.5 stand-in that wakes the ao486 core with INT_RET, then answers IMISS_RQ
// with big-endian IFILL_RET lines from a preloadable memory. Define AO486_RESP_LFSR_DELAY_EN for LFSR response jitter.
module ao486_l15_ifill_responder #(
    parameter int LINE_IDX_W   = 8,
    parameter int RESP_LATENCY = 4,
    parameter int WAKE_DELAY   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  transducer_l15_val,
    input  logic [4:0]            transducer_l15_rqtype,
    input  logic [39:0]           transducer_l15_address,
    input  logic                  transducer_l15_req_ack,
    output logic                  l15_transducer_header_ack,
    output logic                  l15_transducer_ack,
    output logic                  l15_transducer_val,
    output logic [3:0]            l15_transducer_returntype,
    output logic [63:0]           l15_transducer_data_0,
    output logic [63:0]           l15_transducer_data_1,
    output logic [63:0]           l15_transducer_data_2,
    output logic [63:0]           l15_transducer_data_3,
    output logic                  l15_transducer_noncacheable,
    output logic                  l15_transducer_atomic,
    input  logic                  mem_wr_en,
    input  logic [LINE_IDX_W-1:0] mem_wr_idx,
    input  logic [127:0]          mem_wr_data,
    output logic                  err_unsupported
);
    localparam logic [4:0] IMISS_RQ  = 5'b10000;
    localparam logic [3:0] IFILL_RET = 4'b0001;
    localparam logic [3:0] INT_RET   = 4'b0111;

    typedef enum logic [2:0] {S_WAKE, S_INT, S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d, tgt_q, tgt_d, wait_tgt;
    logic [LINE_IDX_W-1:0] idx_q, idx_d;
    logic                  hdr_q, hdr_d, val_q, val_d, err_q, err_d;
    logic [3:0]            rtype_q, rtype_d;
    logic [3:0][63:0]      data_q, data_d;
    logic [127:0]          mem [2**LINE_IDX_W];
    logic [127:0]          line;
    logic                  unused;

    assign unused = ^{transducer_l15_address[39:LINE_IDX_W+4], transducer_l15_address[3:0]};
    assign line   = mem[idx_q];

    always_ff @(posedge clk)
        if (mem_wr_en) mem[mem_wr_idx] <= mem_wr_data;

`ifdef AO486_RESP_LFSR_DELAY_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign wait_tgt = 16'(RESP_LATENCY - 1) + 16'(lfsr_q[2:0]);
`else
    assign wait_tgt = 16'(RESP_LATENCY - 1);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        idx_d   = idx_q;
        hdr_d   = 1'b0;
        val_d   = val_q;
        rtype_d = rtype_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_WAKE:
                if (cnt_q == 16'(WAKE_DELAY - 1)) begin
                    state_d   = S_INT;
                    val_d     = 1'b1;
                    rtype_d   = INT_RET;
                    data_d    = '0;
                    data_d[0] = 64'h0000_0000_0001_0000;
                end else cnt_d = cnt_q + 16'd1;
            S_INT, S_RESP:
                if (transducer_l15_req_ack) begin
                    state_d = S_IDLE;
                    val_d   = 1'b0;
                end
            // hdr_q guard keeps a still-held request from being accepted twice
            S_IDLE:
                if (transducer_l15_val && !hdr_q) begin
                    hdr_d = 1'b1;
                    idx_d = transducer_l15_address[LINE_IDX_W+3:4];
                    cnt_d = '0;
                    tgt_d = wait_tgt;
                    if (transducer_l15_rqtype == IMISS_RQ) state_d = S_WAIT;
                    else err_d = 1'b1;
                end
            S_WAIT:
                if (cnt_q == tgt_q) begin
                    state_d      = S_RESP;
                    val_d        = 1'b1;
                    rtype_d      = IFILL_RET;
                    data_d[1:0]  = '0;
                    data_d[2]    = line[127:64];
                    data_d[3]    = line[63:0];
                end else cnt_d = cnt_q + 16'd1;
            default: state_d = S_WAKE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= S_WAKE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            idx_q   <= '0;
            hdr_q   <= 1'b0;
            val_q   <= 1'b0;
            rtype_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            idx_q   <= idx_d;
            hdr_q   <= hdr_d;
            val_q   <= val_d;
            rtype_q <= rtype_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end

    assign l15_transducer_header_ack   = hdr_q;
    assign l15_transducer_ack          = hdr_q;
    assign l15_transducer_val          = val_q;
    assign l15_transducer_returntype   = rtype_q;
    assign l15_transducer_data_0       = data_q[0];
    assign l15_transducer_data_1       = data_q[1];
    assign l15_transducer_data_2       = data_q[2];
    assign l15_transducer_data_3       = data_q[3];
    assign l15_transducer_noncacheable = 1'b0;
    assign l15_transducer_atomic       = 1'b0;
    assign err_unsupported             = err_q;
endmodule
